sec_display_driver: RTL
=======================

# sec_display_driver

Downstream consumer of the seconds counter. Takes the 7-bit binary seconds value and converts it to two BCD digits with a sequential double-dabble FSM. It then time-multiplexes the digits onto a 2-digit active-low 7-segment display. Sits between the seconds counter and the board display pins.

## Interface
- `FREQ`, 50000000, input clock frequency in Hz.
- `SCAN_HZ`, 1000, digit-switch rate in Hz. `SCAN_DIV = FREQ/SCAN_HZ` must be ≥ 2.

- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: one clock. Reset is synchronous and active-low.
- `sec_count` in 7: binary seconds from the upstream counter. Legal range is 0..99; upstream produces 1..90.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `an` out 2: digit enables, active-low. `an[0]` is units and `an[1]` is tens.
- `bcd` out 8: `{tens, units}`, the last good conversion.
- `busy` out 1: conversion in progress.
- `range_err` out 1: the last converted value was greater than 99.

## Operation
- Input stage: `sample_q <= sec_count` every cycle. `last_q` holds the last value that was converted.
- FSM states are IDLE, SHIFT and LOAD.
  - **IDLE.** If `sample_q != last_q`:
    - load `sh = {8'h00, sample_q}` (15 bits) and set `it = 0`,
    - assert `busy` and go to SHIFT.
  - **SHIFT.** Each cycle:
    - add 3 to each BCD nibble of `sh` that is ≥ 5, then shift `sh` left by 1,
    - increment `it`. After the step with `it == 6` (7 steps total), go to LOAD.
  - **LOAD.** `last_q <= sample_q` as captured at start, held in a shadow register.
    - If the value is ≤ 99: `bcd <= sh[14:7]` and `range_err <= 0`.
    - If the value is > 99: `bcd` is unchanged and `range_err <= 1`.
    - Deassert `busy` and go to IDLE.
- Input changes while busy:
  - `sample_q` keeps tracking the input, and the comparison is redone in IDLE.
  - The final stable value is always converted; intermediate values may be skipped.
- Scan divider:
  - `scan_cnt` counts 0..SCAN_DIV-1 and wraps.
  - At the wrap, `dsel` toggles.
- Digit drive:
  - `dsel=0`: `an = 2'b10`, units digit shown.
  - `dsel=1`: `an = 2'b01`, tens digit shown.
  - `an` and `seg` are registered and change on the same edge.
- Segment map, active-low `{g..a}`:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111, blank = 1111111
- While `range_err=1`, both digits show dash.

## Timing
- Reset values (on an edge with `rst_n=0`):
  - `sample_q`, `last_q` = 0; `bcd` = 8'h00; `busy` = 0; `range_err` = 0
  - FSM = IDLE, `scan_cnt` = 0, `dsel` = 0
  - `an` = 2'b10, `seg` = 1000000 (digit 0)
- Conversion latency, with edge t0 the first to sample a new value into `sample_q`:
  - t1: IDLE→SHIFT, `busy` rises.
  - t2..t8: seven shift steps.
  - t9: LOAD updates `bcd`/`range_err` and `busy` falls.
  - `busy` is high for exactly 8 cycles; the result is visible after t9.
  - `seg` reflects the new `bcd` from the edge after t9, for the currently selected digit.
- Back-to-back: a new value sampled during SHIFT starts its conversion at t10 at the earliest (one IDLE cycle).
- Reset mid-conversion: the conversion is aborted and all reset values are applied on that edge.
- The scan period per digit is exactly SCAN_DIV cycles; the divider is unaffected by conversions.
- No undefined values: nibble values 10..15 can never reach `bcd`, because out-of-range values are blocked in LOAD.

## Configuration
- `SEC_DISPLAY_LZB_EN`
  - Defined: leading-zero blanking. When the tens nibble is 0 and `range_err=0`, the tens digit shows blank (1111111) while its `an` still cycles.
  - Undefined: the tens digit always shows its digit, e.g. "05".

## Test plan
Bench uses FREQ=1000, SCAN_HZ=100, so SCAN_DIV=10.
- Reset: hold `rst_n=0` for 3 cycles.
  - Outputs: `bcd=00`, `busy=0`, `range_err=0`, `an=10`, `seg=1000000`.
  - After release, `an` toggles every 10 cycles.
- Conversion: `sec_count` 0→45.
  - `busy` is high for 8 cycles; `bcd=8'h45` 9 edges after sampling.
  - Units phase `seg=0010010`; tens phase `seg=0011001`.
- Upstream wrap: 90 then 1.
  - `bcd` goes 8'h90 then 8'h01.
  - Tens phase shows 1000000 without the macro, 1111111 with it.
- Out of range: 105 after 37.
  - `range_err=1`, `bcd` stays 8'h37, both digits show 0111111.
  - Then 12 gives `range_err=0`, `bcd=8'h12`.
- Change during busy: 12, 34 on the next cycle, 56 two cycles later.
  - The final `bcd=8'h56` with `range_err=0`.
  - `busy` drops for one cycle between conversions.
- Reset mid-conversion: assert `rst_n=0` at t4 of the conversion of 77.
  - Outputs are at reset values next cycle.
  - After release, 77 is converted afresh: `bcd=8'h77`.

Source files
------------

// File: rtl/sec_display_driver_if.sv
// Signal bundle between the seconds counter, the display driver and the board pins.
// master drives the binary seconds value; slave is the display driver itself.
interface sec_display_driver_if;
  logic [6:0] sec_count;
  logic [6:0] seg;
  logic [1:0] an;
  logic [7:0] bcd;
  logic       busy;
  logic       range_err;

  modport master (output sec_count, input seg, an, bcd, busy, range_err);
  modport slave  (input sec_count, output seg, an, bcd, busy, range_err);
endinterface

// File: rtl/sec_display_driver.sv
// Binary seconds -> two BCD digits (sequential double dabble) -> multiplexed active-low 7-seg.
// Optional SEC_DISPLAY_LZB_EN blanks a leading zero in the tens digit.
//
// state  | meaning
// IDLE   | waiting for sample_q to differ from the last converted value
// SHIFT  | seven add-3/shift-left steps on the 15-bit working register
// LOAD   | commit bcd/range_err from the shadowed input, return to IDLE
module sec_display_driver #(
  parameter int FREQ    = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sec_display_driver_if.slave  disp
);
  localparam int SCAN_DIV = FREQ / SCAN_HZ;
  localparam int CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

  state_t        state, state_nxt;
  logic [6:0]    sample_q;
  logic [6:0]    last_q, last_nxt;
  logic [6:0]    shadow_q, shadow_nxt;
  logic [14:0]   sh_q, sh_nxt, sh_adj;
  logic [2:0]    it_q, it_nxt;
  logic [7:0]    bcd_q, bcd_nxt;
  logic          range_err_q, range_err_nxt;

  logic [CW-1:0] scan_cnt;
  logic          scan_wrap;
  logic          dsel, dsel_nxt;
  logic [3:0]    digit;
  logic [6:0]    seg_q, seg_nxt;
  logic [1:0]    an_q, an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    sh_adj = sh_q;
    if (sh_q[10:7] >= 4'd5)  sh_adj[10:7]  = sh_q[10:7] + 4'd3;
    if (sh_q[14:11] >= 4'd5) sh_adj[14:11] = sh_q[14:11] + 4'd3;

    state_nxt     = state;
    sh_nxt        = sh_q;
    it_nxt        = it_q;
    shadow_nxt    = shadow_q;
    last_nxt      = last_q;
    bcd_nxt       = bcd_q;
    range_err_nxt = range_err_q;

    case (state)
      S_IDLE: begin
        if (sample_q != last_q) begin
          sh_nxt     = {8'h00, sample_q};
          it_nxt     = 3'd0;
          shadow_nxt = sample_q;
          state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_nxt = {sh_adj[13:0], 1'b0};
        it_nxt = it_q + 3'd1;
        if (it_q == 3'd6) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // Over-range values keep the last good digits so nibbles 10..15 never escape.
        last_nxt = shadow_q;
        if (shadow_q <= 7'd99) begin
          bcd_nxt       = sh_q[14:7];
          range_err_nxt = 1'b0;
        end else begin
          range_err_nxt = 1'b1;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));
  assign dsel_nxt  = scan_wrap ? ~dsel : dsel;
  assign digit     = dsel_nxt ? bcd_q[7:4] : bcd_q[3:0];

  // Output registers follow the digit select being loaded so an and seg move together.
  always_comb begin
    an_nxt  = dsel_nxt ? 2'b01 : 2'b10;
    seg_nxt = seg_decode(digit);
`ifdef SEC_DISPLAY_LZB_EN
    if (dsel_nxt && (bcd_q[7:4] == 4'd0)) seg_nxt = 7'b1111111;
`endif
    if (range_err_q) seg_nxt = 7'b0111111;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sample_q    <= 7'd0;
      last_q      <= 7'd0;
      shadow_q    <= 7'd0;
      sh_q        <= 15'd0;
      it_q        <= 3'd0;
      bcd_q       <= 8'h00;
      range_err_q <= 1'b0;
      scan_cnt    <= '0;
      dsel        <= 1'b0;
      an_q        <= 2'b10;
      seg_q       <= 7'b1000000;
    end else begin
      state       <= state_nxt;
      sample_q    <= disp.sec_count;
      last_q      <= last_nxt;
      shadow_q    <= shadow_nxt;
      sh_q        <= sh_nxt;
      it_q        <= it_nxt;
      bcd_q       <= bcd_nxt;
      range_err_q <= range_err_nxt;
      scan_cnt    <= scan_wrap ? '0 : scan_cnt + 1'b1;
      dsel        <= dsel_nxt;
      an_q        <= an_nxt;
      seg_q       <= seg_nxt;
    end
  end

  assign disp.bcd       = bcd_q;
  assign disp.range_err = range_err_q;
  assign disp.busy      = (state != S_IDLE);
  assign disp.an        = an_q;
  assign disp.seg       = seg_q;
endmodule
